peripheral_mpi_rx_buffer_mc: RTL and testbench
==============================================

// Module: peripheral_mpi_rx_buffer_mc
// PURPOSE
//  Multi-channel NoC receive buffer for the MPI peripheral; successor to the single-endpoint ingress path.
//  N independent channels, each with a SIZE-deep flit FIFO, packet counting, flush with drop-to-tail, per-channel IRQ.
//  Sits between the NoC ingress (flit/last/valid/ready per channel) and a simple word register port.
//  The port is driven by the AHB4/AXI4 bus adapters.
// PARAMETERS
//  NOC_FLIT_WIDTH  32  flit width in bits; also the register data width
//  SIZE            16  FIFO depth per channel, in flits; power of two, >=2
//  N               4   channel count, 1..16
//  localparam CW = $clog2(SIZE+1)   width of the count fields
//  localparam AW = $clog2(N)+2      word address width; N=1 gives AW=2
// PORTS
//  clk            in   1                  single clock, rising edge
//  rst            in   1                  asynchronous, active-low reset
//  noc_in_flit    in   N*NOC_FLIT_WIDTH   ingress flits; channel c is [c*W +: W]
//  noc_in_last    in   N                  last flit of the packet, per channel
//  noc_in_valid   in   N                  flit valid, per channel
//  noc_in_ready   out  N                  flit accepted when valid&&ready
//  reg_req        in   1                  register access request, one-cycle pulse
//  reg_we         in   1                  1 = write, 0 = read
//  reg_addr       in   AW                 {channel, offset[1:0]}
//  reg_wdata      in   NOC_FLIT_WIDTH     write data
//  reg_rdata      out  NOC_FLIT_WIDTH     read data, valid while reg_ack=1
//  reg_ack        out  1                  completion, exactly 1 cycle after reg_req
//  reg_err        out  1                  with ack: channel index >=N or reserved offset
//  irq            out  N                  per-channel level interrupt
// BEHAVIOUR
//  Reset (rst=0, async)
//   - Clears all FIFOs and counters; channel state=ACCEPT; irq_en=0.
//   - noc_in_ready=0, reg_ack=0, reg_err=0, reg_rdata=0, irq=0.
//   - After release, noc_in_ready[c] follows the rules below.
//  Register offsets (per channel)
//   - 0 DATA: read pops the head flit.
//   - 1 STATUS, RO: {pkt_cnt[CW-1:0] at [31:16], flit_cnt[CW-1:0] at [15:0]}.
//   - 2 CTRL: bit0 irq_en (R/W); bit1 flush (W1, self-clearing, reads 0).
//   - 3 reserved: ack+err, rdata=0.
//  Ingress
//   - Each FIFO entry stores {last, flit}.
//   - ACCEPT state: ready[c] = !full[c]; push on valid&&ready.
//   - last pushed -> pkt_cnt+1.
//  Read DATA
//   - Non-empty: rdata=head flit (registered, 1-cycle latency), pop on the req cycle.
//   - Popped entry had last=1 -> pkt_cnt-1.
//   - Empty: rdata=0, ack, no pop, err=0.
//  Simultaneous push and pop
//   - flit_cnt unchanged; pkt_cnt nets +1/-1/0.
//   - Push while full and a pop in the same cycle is not allowed: ready is from registered full only.
//  Flush FSM per channel: ACCEPT, DROP
//   - Flush write: FIFO and counters cleared next edge; a same-cycle push is discarded.
//   - Next state is DROP if a packet is in flight (last flit seen ≠ last accepted). This covers the flit at the flush edge when it is not last.
//   - Otherwise next state stays ACCEPT.
//   - DROP: ready[c]=1, flits discarded, no counters move; valid&&last -> ACCEPT.
//  irq[c] = irq_en[c] && pkt_cnt[c]!=0, registered (1 cycle after the count changes).
//  Counters never wrap: flit_cnt<=SIZE by backpressure; pkt_cnt<=flit_cnt.
//  A packet longer than SIZE stalls until software drains partial flits. pkt_cnt counts only completed packets.
// STRUCTURE
//  peripheral_mpi_pkg
//   - Register offset constants (MPI_REG_DATA/STATUS/CTRL).
//   - CTRL bit positions.
//   - typedef enum logic {CH_ACCEPT, CH_DROP} mpi_ch_state_t.
//  Sub-module peripheral_mpi_rx_channel: one per channel via generate.
//   - Contains the FIFO, counters, FSM and irq_en.
//  Top level: address decode, registered rdata/ack/err mux.
// TESTING
//  1 Ch0: push 3-flit packet 0xA0..0xA2 (last on A2)
//    -> STATUS=0x0001_0003, irq[0]=0 until CTRL=1, then irq[0]=1.
//  2 Read DATA x3 -> rdata 0xA0,0xA1,0xA2, each ack 1 cycle after req.
//    -> Then STATUS=0, irq[0]=0. Fourth read -> rdata=0, err=0.
//  3 Ch1: push 16 flits without last
//    -> ready[1]=0, flit_cnt=16, pkt_cnt=0.
//    -> One DATA read -> ready[1]=1 next cycle, 17th flit accepted.
//  4 Ch2: 2 flits of a packet accepted, then write CTRL=2
//    -> STATUS=0, ready[2]=1 in DROP, 3 further flits discarded through last.
//    -> Next packet 0xB0(last) -> STATUS=0x0001_0001.
//  5 Channels 0 and 3 pushing while ch0 DATA is read the same cycle
//    -> independent counts, ch0 flit_cnt unchanged, no cross-talk.
//  6 Assert rst mid-packet on all channels
//    -> immediate ready=0, irq=0, all STATUS=0 after release, channels in ACCEPT.
//    -> Reads to channel index>=N or offset 3 -> ack with err=1.

Source files
------------

// File: rtl/peripheral_mpi_pkg.sv
// Shared constants and types for the MPI multi-channel receive buffer.
package peripheral_mpi_pkg;

  localparam logic [1:0] MPI_REG_DATA   = 2'd0;
  localparam logic [1:0] MPI_REG_STATUS = 2'd1;
  localparam logic [1:0] MPI_REG_CTRL   = 2'd2;

  localparam int MPI_CTRL_IRQ_EN     = 0;
  localparam int MPI_CTRL_FLUSH      = 1;
  localparam int MPI_STATUS_PKT_LSB  = 16;

  typedef enum logic {CH_ACCEPT, CH_DROP} mpi_ch_state_t;

endpackage

// File: rtl/peripheral_mpi_rx_channel.sv
// One receive channel: {last, flit} FIFO, flit/packet counters, flush FSM and irq.
//  state     | meaning
//  CH_ACCEPT | flits are pushed into the FIFO while not full
//  CH_DROP   | remainder of a flushed packet is swallowed up to its last flit
module peripheral_mpi_rx_channel
  import peripheral_mpi_pkg::*;
#(
  parameter int W    = 32,
  parameter int SIZE = 16,
  parameter int CW   = $clog2(SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_flit,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          pop_req,
  input  logic          flush,
  input  logic          ctrl_we,
  input  logic          irq_en_wdata,
  output logic [W-1:0]  head_flit,
  output logic          empty,
  output logic [CW-1:0] flit_cnt,
  output logic [CW-1:0] pkt_cnt,
  output logic          irq_en,
  output logic          irq
);

  localparam int PW = $clog2(SIZE);

  logic [W:0]    mem [SIZE];
  logic [PW-1:0] wr_ptr, rd_ptr;
  mpi_ch_state_t state, state_nxt;
  logic          run, in_pkt, full, hs, push, pop, push_last, pop_last;

  assign full      = (flit_cnt == CW'(SIZE));
  assign empty     = (flit_cnt == '0);
  // run holds ready low through reset and for the first cycle after release
  assign in_ready  = run && ((state == CH_DROP) || !full);
  assign hs        = in_valid && in_ready;
  assign push      = hs && (state == CH_ACCEPT) && !flush;
  assign pop       = pop_req && !empty && !flush;
  assign push_last = push && in_last;
  assign pop_last  = pop && mem[rd_ptr][W];
  assign head_flit = mem[rd_ptr][W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      CH_ACCEPT: if (flush) state_nxt = (hs ? !in_last : in_pkt) ? CH_DROP : CH_ACCEPT;
      CH_DROP:   if (hs && in_last) state_nxt = CH_ACCEPT;
      default:   state_nxt = CH_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CH_ACCEPT;
      run      <= 1'b0;
      in_pkt   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      flit_cnt <= '0;
      pkt_cnt  <= '0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      if (flush) begin
        in_pkt   <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        flit_cnt <= '0;
        pkt_cnt  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          in_pkt <= !in_last;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        flit_cnt <= flit_cnt + CW'(push) - CW'(pop);
        pkt_cnt  <= pkt_cnt + CW'(push_last) - CW'(pop_last);
      end
      if (ctrl_we) irq_en <= irq_en_wdata;
      irq <= irq_en && (pkt_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_flit};
  end

endmodule

// File: rtl/peripheral_mpi_rx_buffer_mc.sv
// Multi-channel NoC receive buffer with a word register port for the bus adapters.
module peripheral_mpi_rx_buffer_mc
  import peripheral_mpi_pkg::*;
#(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16,
  parameter int N              = 4,
  localparam int CW            = $clog2(SIZE + 1),
  localparam int AW            = $clog2(N) + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N*NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic [N-1:0]                noc_in_last,
  input  logic [N-1:0]                noc_in_valid,
  output logic [N-1:0]                noc_in_ready,
  input  logic                        reg_req,
  input  logic                        reg_we,
  input  logic [AW-1:0]               reg_addr,
  input  logic [NOC_FLIT_WIDTH-1:0]   reg_wdata,
  output logic [NOC_FLIT_WIDTH-1:0]   reg_rdata,
  output logic                        reg_ack,
  output logic                        reg_err,
  output logic [N-1:0]                irq
);

  localparam int W = NOC_FLIT_WIDTH;

  logic [W-1:0]  head_flit [N];
  logic [CW-1:0] flit_cnt  [N];
  logic [CW-1:0] pkt_cnt   [N];
  logic [N-1:0]  empty, irq_en, pop_ch, flush_ch, ctrl_we_ch;
  logic [AW-1:0] ch_sel;
  logic [1:0]    off;
  logic          ch_ok, addr_err, unused_wdata;
  logic [W-1:0]  rd_mux;

  assign ch_sel       = reg_addr >> 2;
  assign off          = reg_addr[1:0];
  assign ch_ok        = (ch_sel < AW'(N));
  assign addr_err     = !ch_ok || (off == 2'd3);
  assign unused_wdata = ^reg_wdata[W-1:2];

  for (genvar c = 0; c < N; c++) begin : g_ch
    logic hit;
    assign hit           = reg_req && ch_ok && (ch_sel == AW'(c));
    assign pop_ch[c]     = hit && !reg_we && (off == MPI_REG_DATA);
    assign ctrl_we_ch[c] = hit && reg_we && (off == MPI_REG_CTRL);
    assign flush_ch[c]   = ctrl_we_ch[c] && reg_wdata[MPI_CTRL_FLUSH];

    peripheral_mpi_rx_channel #(.W(W), .SIZE(SIZE), .CW(CW)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .in_flit      (noc_in_flit[c*W +: W]),
      .in_last      (noc_in_last[c]),
      .in_valid     (noc_in_valid[c]),
      .in_ready     (noc_in_ready[c]),
      .pop_req      (pop_ch[c]),
      .flush        (flush_ch[c]),
      .ctrl_we      (ctrl_we_ch[c]),
      .irq_en_wdata (reg_wdata[MPI_CTRL_IRQ_EN]),
      .head_flit    (head_flit[c]),
      .empty        (empty[c]),
      .flit_cnt     (flit_cnt[c]),
      .pkt_cnt      (pkt_cnt[c]),
      .irq_en       (irq_en[c]),
      .irq          (irq[c])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < N; c++) begin
      if (ch_sel == AW'(c)) begin
        case (off)
          MPI_REG_DATA:   if (!empty[c]) rd_mux = head_flit[c];
          MPI_REG_STATUS: begin
            rd_mux[0 +: CW]                  = flit_cnt[c];
            rd_mux[MPI_STATUS_PKT_LSB +: CW] = pkt_cnt[c];
          end
          MPI_REG_CTRL:   rd_mux[MPI_CTRL_IRQ_EN] = irq_en[c];
          default:        rd_mux = '0;
        endcase
      end
    end
    if (reg_we || addr_err) rd_mux = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_ack   <= 1'b0;
      reg_err   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack   <= reg_req;
      reg_err   <= reg_req && addr_err;
      reg_rdata <= reg_req ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_peripheral_mpi_rx_buffer_mc.sv
// Scoreboard bench for the multi-channel MPI receive buffer.
module tb_peripheral_mpi_rx_buffer_mc;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] noc_in_flit;
  logic [N-1:0]   noc_in_last, noc_in_valid, noc_in_ready, irq;
  logic           reg_req, reg_we, reg_ack, reg_err;
  logic [AW-1:0]  reg_addr;
  logic [W-1:0]   reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  peripheral_mpi_rx_buffer_mc #(.NOC_FLIT_WIDTH(W), .SIZE(16), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .noc_in_flit  (noc_in_flit),
    .noc_in_last  (noc_in_last),
    .noc_in_valid (noc_in_valid),
    .noc_in_ready (noc_in_ready),
    .reg_req      (reg_req),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .reg_ack      (reg_ack),
    .reg_err      (reg_err),
    .irq          (irq)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] sb_q[$];
  logic        req_at_edge = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) req_at_edge <= reg_req;

  always @(negedge clk) begin
    logic [32:0] e;
    if (reg_ack || req_at_edge) chk("ack_timing", 32'(reg_ack), 32'(req_at_edge));
    if (reg_ack) begin
      if (sb_q.size() == 0) chk("sb_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("rdata", reg_rdata, e[31:0]);
        chk("err", 32'(reg_err), 32'(e[32]));
      end
    end
  end

  task automatic reg_rd(logic [AW-1:0] a, logic [31:0] exp, logic exp_err = 1'b0);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
    sb_q.push_back({exp_err, exp});
    @(negedge clk);
    reg_req = 1'b0;
  endtask

  task automatic reg_wr(logic [AW-1:0] a, logic [31:0] d, logic exp_err = 1'b0);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    sb_q.push_back({exp_err, 32'd0});
    @(negedge clk);
    reg_req = 1'b0; reg_we = 1'b0;
  endtask

  task automatic push(int ch, logic [31:0] f, logic l);
    noc_in_flit[ch*W +: W] = f;
    noc_in_last[ch]  = l;
    noc_in_valid[ch] = 1'b1;
    for (int i = 0; i < 50 && !noc_in_ready[ch]; i++) @(negedge clk);
    if (!noc_in_ready[ch]) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    noc_in_valid[ch] = 1'b0;
    noc_in_last[ch]  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; noc_in_flit = '0; noc_in_last = '0; noc_in_valid = '0;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    @(negedge clk);
    chk("rst_ready", 32'(noc_in_ready), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ack", 32'(reg_ack), 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(noc_in_ready), 32'hF);

    // 1: three-flit packet on ch0, irq gated by irq_en
    push(0, 32'hA0, 1'b0); push(0, 32'hA1, 1'b0); push(0, 32'hA2, 1'b1);
    reg_rd(4'd1, 32'h0001_0003);
    chk("t1_irq_off", 32'(irq[0]), 32'd0);
    reg_wr(4'd2, 32'd1);
    chk("t1_irq_reg_delay", 32'(irq[0]), 32'd0);
    @(negedge clk);
    chk("t1_irq_on", 32'(irq[0]), 32'd1);
    reg_rd(4'd2, 32'd1);

    // 2: drain ch0
    reg_rd(4'd0, 32'hA0); reg_rd(4'd0, 32'hA1); reg_rd(4'd0, 32'hA2);
    reg_rd(4'd1, 32'h0);
    chk("t2_irq_clear", 32'(irq[0]), 32'd0);
    reg_rd(4'd0, 32'h0);
    reg_wr(4'd2, 32'd0);

    // 3: fill ch1 to backpressure
    for (int i = 0; i < 16; i++) push(1, 32'hC0 + 32'(i), 1'b0);
    chk("t3_full_ready", 32'(noc_in_ready[1]), 32'd0);
    reg_rd(4'd5, 32'h0000_0010);
    reg_rd(4'd4, 32'hC0);
    chk("t3_ready_after_pop", 32'(noc_in_ready[1]), 32'd1);
    push(1, 32'hD0, 1'b1);
    reg_rd(4'd5, 32'h0001_0010);

    // 4: flush ch2 mid-packet, drop to tail
    push(2, 32'hE0, 1'b0); push(2, 32'hE1, 1'b0);
    reg_wr(4'd10, 32'd2);
    reg_rd(4'd9, 32'h0);
    chk("t4_drop_ready", 32'(noc_in_ready[2]), 32'd1);
    push(2, 32'hF0, 1'b0); push(2, 32'hF1, 1'b0); push(2, 32'hF2, 1'b1);
    reg_rd(4'd9, 32'h0);
    push(2, 32'hB0, 1'b1);
    reg_rd(4'd9, 32'h0001_0001);
    reg_rd(4'd8, 32'hB0);

    // 5: simultaneous push/pop on ch0 with ch3 pushing
    push(0, 32'h50, 1'b0); push(0, 32'h51, 1'b1);
    chk("t5_ready", 32'(noc_in_ready & 4'b1001), 32'h9);
    noc_in_flit[0*W +: W] = 32'h52; noc_in_last[0] = 1'b1; noc_in_valid[0] = 1'b1;
    noc_in_flit[3*W +: W] = 32'h30; noc_in_last[3] = 1'b1; noc_in_valid[3] = 1'b1;
    reg_rd(4'd0, 32'h50);
    noc_in_valid = '0; noc_in_last = '0;
    reg_rd(4'd1, 32'h0002_0002);
    reg_rd(4'd13, 32'h0001_0001);
    reg_rd(4'd5, 32'h0001_0010);
    reg_rd(4'd9, 32'h0);

    // 6: reset mid-packet
    reg_wr(4'd2, 32'd1);
    @(negedge clk);
    chk("t6_irq_pre", 32'(irq), 32'h1);
    for (int c = 0; c < N; c++) noc_in_flit[c*W +: W] = 32'h60 + 32'(c);
    noc_in_valid = 4'hF;
    @(posedge clk); #2 rst = 1'b0; #1;
    chk("t6_rst_ready", 32'(noc_in_ready), 32'h0);
    chk("t6_rst_irq", 32'(irq), 32'h0);
    @(negedge clk); noc_in_valid = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t6_post_ready", 32'(noc_in_ready), 32'hF);
    for (int c = 0; c < N; c++) reg_rd(AW'(c*4 + 1), 32'h0);
    reg_rd(4'd2, 32'h0);
    push(2, 32'h70, 1'b1);
    reg_rd(4'd9, 32'h0001_0001);
    reg_rd(4'd3, 32'h0, 1'b1);
    reg_wr(4'd7, 32'h3, 1'b1);

    @(negedge clk); @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
